program_loader: RTL and testbench

- Writer side of the CPU's instruction store: accepts a framed program from a host over a valid/ready byte stream and writes it into an internal 16-entry program RAM.
- The RAM's read port feeds the CPU in place of the ROM. Address comes from the program counter; value and function go out to the register datapath and the controller.
- Holds the CPU in NOP until a complete, checksum-verified program is resident, then asserts cpu_run.

---
 rtl/program_loader_if.sv | 32 +++
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
//------------------------------------------------------------------------------
// program_loader_if : host byte stream, CPU read port and status of the loader
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface program_loader_if #(
  parameter int AW = 4
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_val;
  logic [3:0]    cpu_func;
  logic          cpu_run;
  logic          load_error;
  logic          busy;

  modport master (
    output in_valid, in_data, reload, cpu_addr,
    input  in_ready, cpu_val, cpu_func, cpu_run, load_error, busy
  );

  modport slave (
    input  in_valid, in_data, reload, cpu_addr,
    output in_ready, cpu_val, cpu_func, cpu_run, load_error, busy
  );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
//------------------------------------------------------------------------------
// program_loader : loads a framed, checksummed program into a 16-word RAM
//                  and releases the CPU once the image is complete.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_loader #(
  parameter int         DEPTH    = 16,
  parameter logic [3:0] NOP_FUNC = 4'h0
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam int               c_AW   = $clog2(DEPTH);
  localparam logic [c_AW-1:0]  c_LAST = c_AW'(DEPTH - 1);
  localparam logic [4:0]       c_FULL = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CHK  = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_len,   w_len_nxt;
  logic [c_AW-1:0] r_cnt,   w_cnt_nxt;
  logic [7:0]      r_chk,   w_chk_nxt;
  logic            r_run;
  logic            r_err;

  logic            w_accept;
  logic            w_we;
  logic [c_AW-1:0] w_waddr;
  logic [7:0]      w_wdata;
  logic [7:0]      w_rd;
  logic [7:0]      r_mem [DEPTH];

  assign bus.in_ready = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign bus.busy     = bus.in_ready || (r_state == S_FILL);
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_chk_nxt   = r_chk;
    w_we        = 1'b0;
    w_waddr     = r_cnt;
    w_wdata     = bus.in_data;
    case (r_state)
      S_HDR: begin
        if (w_accept) begin
          if ((bus.in_data[7:5] == 3'b000) && (bus.in_data[4:0] != 5'd0) &&
              (bus.in_data[4:0] <= c_FULL)) begin
            w_len_nxt   = bus.in_data[4:0];
            w_chk_nxt   = bus.in_data;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_we      = 1'b1;
          w_chk_nxt = r_chk ^ bus.in_data;
          // With a full-depth program the counter wraps to 0 here; nothing reads it afterwards.
          w_cnt_nxt = r_cnt + 1'b1;
          if ({1'b0, r_cnt} == (r_len - 5'd1)) begin
            w_state_nxt = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (w_accept) begin
          if (bus.in_data == r_chk) begin
            w_state_nxt = (r_len == c_FULL) ? S_DONE : S_FILL;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_FILL: begin
        w_we      = 1'b1;
        w_wdata   = {NOP_FUNC, 4'h0};
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE, S_ERR: begin
        if (bus.reload) begin
          w_state_nxt = S_HDR;
          w_len_nxt   = '0;
          w_cnt_nxt   = '0;
          w_chk_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_HDR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HDR;
      r_len   <= '0;
      r_cnt   <= '0;
      r_chk   <= '0;
      r_run   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_chk   <= w_chk_nxt;
      r_run   <= (w_state_nxt == S_DONE);
      r_err   <= (w_state_nxt == S_ERR);
    end
  end

  // Program store is deliberately not reset; the read port is gated by r_run instead.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign w_rd           = r_mem[bus.cpu_addr];
  assign bus.cpu_val    = r_run ? w_rd[3:0] : 4'h0;
  assign bus.cpu_func   = r_run ? w_rd[7:4] : NOP_FUNC;
  assign bus.cpu_run    = r_run;
  assign bus.load_error = r_err;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
//------------------------------------------------------------------------------
// tb_program_loader : randomized load traffic with a queue-based scoreboard
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if #(.AW(4)) bus ();

  program_loader #(.DEPTH(16), .NOP_FUNC(4'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit           err;
    int           at;
    logic [127:0] img;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every new DONE/ERR outcome pops one expectation and sweeps the read port.
  initial begin
    bit   pr = 1'b0;
    bit   pe = 1'b0;
    exp_t e;
    bus.cpu_addr = 4'h0;
    forever begin
      @(posedge clk);
      #2;
      if ((bus.cpu_run && !pr) || (bus.load_error && !pe)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_outcome: got run=%0b err=%0b want nothing pending", bus.cpu_run, bus.load_error);
        end else begin
          e = sb.pop_front();
          check("outcome_err", 32'(bus.load_error), 32'(e.err));
          check("outcome_run", 32'(bus.cpu_run), 32'(!e.err));
          check("outcome_cycle", cyc, e.at);
          for (int i = 0; i < 16; i++) begin
            bus.cpu_addr = 4'(i);
            #1;
            check($sformatf("ram_word[%0d]", i), {24'h0, bus.cpu_func, bus.cpu_val},
                  e.err ? 32'h0 : {24'h0, e.img[i*8 +: 8]});
          end
        end
        done_cnt++;
      end
      pr = bus.cpu_run;
      pe = bus.load_error;
    end
  end

  // Offers one byte, optionally after random idle cycles; returns the consuming edge.
  task automatic send(input logic [7:0] b, input bit gaps, output int acc);
    int k;
    @(negedge clk);
    while (gaps && ($urandom_range(0, 2) == 0)) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    acc          = cyc;
    bus.in_valid = 1'b0;
  endtask

  // After an outcome is due, keep offering junk and require it is never accepted.
  task automatic wait_outcome(input int start);
    int k = 0;
    while (done_cnt == start && k < 60) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      check("ready_low_after_load", 32'(bus.in_ready), 32'h0);
      k++;
    end
    bus.in_valid = 1'b0;
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL outcome_timeout: got no outcome want one");
    end
  endtask

  task automatic do_load(input int n, input logic [127:0] words, input bit gaps,
                         input bit force_cs, input logic [7:0] cs_val);
    logic [7:0]   chk;
    logic [7:0]   cs;
    logic [127:0] img;
    exp_t         e;
    int           t;
    int           start;
    start = done_cnt;
    chk   = 8'(n);
    send(8'(n), gaps, t);
    img = '0;
    for (int i = 0; i < n; i++) begin
      send(words[i*8 +: 8], gaps, t);
      chk           = chk ^ words[i*8 +: 8];
      img[i*8 +: 8] = words[i*8 +: 8];
    end
    cs = force_cs ? cs_val : chk;
    send(cs, gaps, t);
    e.err = (cs != chk);
    e.at  = e.err ? t : t + (16 - n);
    e.img = img;
    sb.push_back(e);
    wait_outcome(start);
  endtask

  task automatic do_reload();
    @(negedge clk);
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.reload = 1'b0;
    check("reload_in_ready", 32'(bus.in_ready), 32'h1);
    check("reload_load_error", 32'(bus.load_error), 32'h0);
    check("reload_cpu_run", 32'(bus.cpu_run), 32'h0);
    check("reload_busy", 32'(bus.busy), 32'h1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_cpu_run", 32'(bus.cpu_run), 32'h0);
    check("rst_load_error", 32'(bus.load_error), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h1);
    check("rst_cpu_func", 32'(bus.cpu_func), 32'h0);
    check("rst_cpu_val", 32'(bus.cpu_val), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [127:0] w;
    logic [7:0]   hdrs [3];
    int           t;
    int           start;
    exp_t         e;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.reload   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pulse_reset();

    w = '0;
    w[23:0] = 24'h39_27_15;
    do_load(3, w, 1'b0, 1'b0, 8'h00);

    do_reload();
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(i);
    do_load(16, w, 1'b0, 1'b0, 8'h00);

    do_reload();
    w = '0;
    w[15:0] = 16'hB2_A1;
    do_load(2, w, 1'b0, 1'b1, 8'h00);
    do_reload();

    hdrs[0] = 8'h00;
    hdrs[1] = 8'h11;
    hdrs[2] = 8'h23;
    for (int h = 0; h < 3; h++) begin
      pulse_reset();
      start = done_cnt;
      send(hdrs[h], 1'b0, t);
      e.err = 1'b1;
      e.at  = t;
      e.img = '0;
      sb.push_back(e);
      wait_outcome(start);
    end

    pulse_reset();
    w = '0;
    w[39:0] = 40'h4E_3D_2C_1B_0A;
    do_load(5, w, 1'b0, 1'b0, 8'h00);
    do_reload();
    do_load(5, w, 1'b1, 1'b0, 8'h00);

    do_reload();
    send(8'h04, 1'b0, t);
    send(8'h11, 1'b0, t);
    send(8'h22, 1'b0, t);
    pulse_reset();
    w = '0;
    w[7:0] = 8'h5C;
    do_load(1, w, 1'b0, 1'b0, 8'h00);

    for (int r = 0; r < 20; r++) begin
      int n;
      do_reload();
      n = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'($urandom);
      do_load(n, w, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
